filtro_iir_biquad_param: RTL
============================

Name: filtro_iir_biquad_param

Overview:
- Parametrised, multi-channel, second-order IIR (biquad) filter. It is the next generation of the fixed 25-bit low-pass filter block.
- Runtime-loadable coefficients replace hard-wired constants, so one block serves the 200 Hz low-pass and any other biquad response.
- Sits between the ADC sample interface and the DAC/output path. Keeps the Uk/Bandera_ADC → Yk/Bandera_Listo handshake.
- Uses one time-multiplexed multiplier-accumulator, processing one sample per start pulse.

Parameters:
- N, 25, sample, coefficient and output width; two's complement.
- F, 12, fractional bits of coefficients (Q(N-F-1).F); 1.0 = 2^F.
- CH, 2, number of independent channels, each with its own history and coefficient set.
- CW, 1, width of channel select; must satisfy 2^CW >= CH.

Ports:
- Clk, input, 1, system clock; all logic on the rising edge.
- Reset, input, 1, synchronous, active-high reset.
- Uk, input, N, input sample; signed.
- Canal, input, CW, channel of the sample presented with Bandera_ADC.
- Bandera_ADC, input, 1, start pulse; sampled only in IDLE.
- Coef_We, input, 1, coefficient write strobe.
- Coef_Canal, input, CW, channel addressed by the coefficient write.
- Coef_Sel, input, 3, coefficient index: 0=b0, 1=b1, 2=b2, 3=a1, 4=a2; values 5–7 are ignored.
- Coef_Data, input, N, coefficient value; signed, QF format.
- Yk, input/output: output, N, last filtered output; held until the next result.
- Canal_Yk, output, CW, channel of the current Yk.
- Bandera_Listo, output, 1, one-cycle pulse when Yk is updated.
- Ocupado, output, 1, high while not in IDLE.
- Saturo, output, 1, sticky per-result flag; high with Yk if the result was clipped.

Behaviour:
Difference equation:
- y[k] = b0·u[k] + b1·u[k-1] + b2·u[k-2] − a1·y[k-1] − a2·y[k-2], with separate history per channel.

Reset state:
- Yk=0, Canal_Yk=0, Bandera_Listo=0, Ocupado=0, Saturo=0.
- All histories cleared to 0 and all coefficients cleared to 0.
- FSM in IDLE. Reset mid-operation aborts the computation: no Listo pulse and no history update.

FSM states:
- IDLE: if Bandera_ADC=1 and Canal<CH, latch Uk and Canal, clear the accumulator, go to MAC. If Canal>=CH, drop the request and stay in IDLE.
- MAC: five cycles with term index t=0..4; accumulate the signed products in the order b0u, b1u1, b2u2, −a1y1, −a2y2.
- SAT: arithmetic right shift of the accumulator by F (floor rounding), then clamp to [−2^(N-1), 2^(N-1)−1]; set Saturo if clamped.
- DONE: write Yk and Canal_Yk; shift histories (u2←u1, u1←u, y2←y1, y1←saturated y); pulse Bandera_Listo; return to IDLE.

Timing and width:
- Latency: Bandera_ADC sampled at edge 0 gives Bandera_Listo high during the cycle after edge 7. The throughput limit is one sample per 8 cycles.
- Accumulator width is 2N+3 bits, so no internal overflow is possible.

Boundary conditions:
- Bandera_ADC while Ocupado=1: ignored; no queueing.
- Coef_We: accepted only in IDLE. While Ocupado=1 the write is dropped, so coefficients never change mid-computation.
- Coef_We and Bandera_ADC in the same IDLE cycle: the write commits and the new sample uses the updated coefficient.
- Coef_Canal>=CH or Coef_Sel>4: write ignored.
- Histories are stored in the saturated output domain; y history never exceeds N bits.

Decomposition:
- Package filtro_pkg holds:
  - FSM state encoding (IDLE, MAC, SAT, DONE).
  - Coefficient index constants (COEF_B0..COEF_A2).
  - A function for the saturating N-bit clamp.
- One sub-module, filtro_mac: signed N×N multiplier plus (2N+3)-bit accumulator with clear/enable/negate controls.

Test Plan (N=25, F=12, CH=2):
- Identity: ch0 b0=4096, others 0; Uk=12345 → Yk=12345, Bandera_Listo exactly 8 edges after start, one cycle wide.
- First-order: ch0 b0=2048, a1=−2048; Uk=4096 repeated → Yk sequence 2048, 3072, 3584, 3840.
- Saturation: b0=8192 (2.0); Uk=2^24−1 → Yk=2^24−1, Saturo=1. Uk=−2^24 → Yk=−2^24, Saturo=1.
- Channel isolation: ch0 as the first-order case, ch1 identity; interleave ch0/ch1 samples of 4096 → ch1 always 4096, ch0 follows 2048, 3072, …, unaffected by ch1.
- Busy/collision: Bandera_ADC re-asserted 3 cycles after a start and Coef_We during MAC → exactly one Listo pulse, coefficient unchanged on readback via the next identity result.
- Reset mid-MAC: assert Reset at cycle 3 → no Listo pulse; next sample on ch0 with the first-order coefficients reloaded yields 2048 (history cleared).

Source files
------------

// File: rtl/filtro_pkg.sv
// Shared definitions for the biquad IIR filter: FSM encoding, coefficient
// indices and the saturating clamp used on the scaled accumulator.
package filtro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MAC,
    ST_SAT,
    ST_DONE
  } state_t;

  localparam logic [2:0] COEF_B0 = 3'd0;
  localparam logic [2:0] COEF_B1 = 3'd1;
  localparam logic [2:0] COEF_B2 = 3'd2;
  localparam logic [2:0] COEF_A1 = 3'd3;
  localparam logic [2:0] COEF_A2 = 3'd4;
  localparam int         NUM_COEF = 5;

  // Clamp a 64-bit signed value into the n-bit two's complement range.
  // The 64-bit carrier limits the filter to N <= 30 (2N+3 <= 64).
  function automatic logic signed [63:0] sat_clamp(input logic signed [63:0] v,
                                                   input int n,
                                                   output logic clipped);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    clipped = 1'b0;
    sat_clamp = v;
    if (v > hi) begin
      sat_clamp = hi;
      clipped = 1'b1;
    end else if (v < lo) begin
      sat_clamp = lo;
      clipped = 1'b1;
    end
  endfunction

endpackage

// File: rtl/filtro_mac.sv
// Time-multiplexed signed multiply-accumulate: one N x N product per enabled
// cycle, added to or subtracted from a (2N+3)-bit accumulator.
module filtro_mac
  import filtro_pkg::*;
#(
  parameter int N = 25
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  en,
  input  logic                  neg,
  input  logic signed [N-1:0]   op_a,
  input  logic signed [N-1:0]   op_b,
  output logic signed [2*N+2:0] acc
);

  localparam int ACC_W = 2 * N + 3;

  logic signed [2*N-1:0]   prod;
  logic signed [ACC_W-1:0] prod_ext;

  assign prod     = op_a * op_b;
  assign prod_ext = ACC_W'(prod);

  always_ff @(posedge clk) begin
    if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= neg ? (acc - prod_ext) : (acc + prod_ext);
    end
  end

endmodule

// File: rtl/filtro_iir_biquad_param.sv
// Multi-channel biquad IIR filter with runtime-loadable Q.F coefficients,
// sharing one MAC across the five terms of the difference equation.
module filtro_iir_biquad_param
  import filtro_pkg::*;
#(
  parameter int N  = 25,
  parameter int F  = 12,
  parameter int CH = 2,
  parameter int CW = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic signed [N-1:0]  Uk,
  input  logic [CW-1:0]        Canal,
  input  logic                 Bandera_ADC,
  input  logic                 Coef_We,
  input  logic [CW-1:0]        Coef_Canal,
  input  logic [2:0]           Coef_Sel,
  input  logic signed [N-1:0]  Coef_Data,
  output logic signed [N-1:0]  Yk,
  output logic [CW-1:0]        Canal_Yk,
  output logic                 Bandera_Listo,
  output logic                 Ocupado,
  output logic                 Saturo
);

  localparam int ACC_W = 2 * N + 3;

  state_t state, state_nxt;
  logic [2:0] term_idx;

  logic signed [N-1:0] coef [CH][NUM_COEF];
  logic signed [N-1:0] u1 [CH];
  logic signed [N-1:0] u2 [CH];
  logic signed [N-1:0] y1 [CH];
  logic signed [N-1:0] y2 [CH];

  logic signed [N-1:0] u_p0;
  logic [CW-1:0]       ch_p0;
  logic signed [N-1:0] y_p1;
  logic                sat_p1;

  logic signed [N-1:0]     op_coef, op_data;
  logic                    op_neg;
  logic signed [ACC_W-1:0] acc;
  logic signed [N-1:0]     y_sat_c;
  logic                    clip_c;
  logic                    start, coef_wr, mac_clr, mac_en;

  function automatic logic ch_ok(input logic [CW-1:0] c);
    return 32'(c) < 32'(CH);
  endfunction

  // Floor-scale by 2^F (arithmetic shift) and clip to N bits.
  function automatic logic signed [N-1:0] scale_sat(input logic signed [ACC_W-1:0] a,
                                                    output logic clipped);
    logic signed [63:0] wide;
    wide = sat_clamp(64'(a >>> F), N, clipped);
    return N'(wide);
  endfunction

  assign Ocupado = (state != ST_IDLE);

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    coef_wr   = 1'b0;
    mac_clr   = 1'b0;
    mac_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        coef_wr = Coef_We && ch_ok(Coef_Canal) && (Coef_Sel <= COEF_A2);
        if (Bandera_ADC && ch_ok(Canal)) begin
          start     = 1'b1;
          mac_clr   = 1'b1;
          state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        mac_en = 1'b1;
        if (term_idx == COEF_A2) state_nxt = ST_SAT;
      end
      ST_SAT:  state_nxt = ST_DONE;
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= ST_IDLE;
      term_idx <= '0;
    end else begin
      state <= state_nxt;
      if (start)       term_idx <= '0;
      else if (mac_en) term_idx <= term_idx + 3'd1;
    end
  end

  // Operand selection: feedback terms are subtracted.
  always_comb begin
    op_coef = coef[ch_p0][COEF_B0];
    op_data = u_p0;
    op_neg  = 1'b0;
    case (term_idx)
      COEF_B0: begin op_coef = coef[ch_p0][COEF_B0]; op_data = u_p0; end
      COEF_B1: begin op_coef = coef[ch_p0][COEF_B1]; op_data = u1[ch_p0]; end
      COEF_B2: begin op_coef = coef[ch_p0][COEF_B2]; op_data = u2[ch_p0]; end
      COEF_A1: begin op_coef = coef[ch_p0][COEF_A1]; op_data = y1[ch_p0]; op_neg = 1'b1; end
      default: begin op_coef = coef[ch_p0][COEF_A2]; op_data = y2[ch_p0]; op_neg = 1'b1; end
    endcase
  end

  filtro_mac #(.N(N)) u_mac (
    .clk  (Clk),
    .clr  (mac_clr),
    .en   (mac_en),
    .neg  (op_neg),
    .op_a (op_coef),
    .op_b (op_data),
    .acc  (acc)
  );

  always_comb y_sat_c = scale_sat(acc, clip_c);

  // p0: sample capture; p1: scaled and clipped result.
  always_ff @(posedge Clk) begin
    if (start) begin
      u_p0  <= Uk;
      ch_p0 <= Canal;
    end
    if (state == ST_SAT) begin
      y_p1   <= y_sat_c;
      sat_p1 <= clip_c;
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      Yk            <= '0;
      Canal_Yk      <= '0;
      Saturo        <= 1'b0;
      Bandera_Listo <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        u1[c] <= '0;
        u2[c] <= '0;
        y1[c] <= '0;
        y2[c] <= '0;
        for (int k = 0; k < NUM_COEF; k++) coef[c][k] <= '0;
      end
    end else begin
      Bandera_Listo <= (state == ST_DONE);
      if (state == ST_DONE) begin
        Yk           <= y_p1;
        Canal_Yk     <= ch_p0;
        Saturo       <= sat_p1;
        u2[ch_p0]    <= u1[ch_p0];
        u1[ch_p0]    <= u_p0;
        y2[ch_p0]    <= y1[ch_p0];
        y1[ch_p0]    <= y_p1;
      end
      if (coef_wr) coef[Coef_Canal][Coef_Sel] <= Coef_Data;
    end
  end

endmodule
